// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port synchronous memory.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  req0;
   logic                  req1;
   logic                  we0;
   logic                  we1;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  gnt0;
   logic                  gnt1;
   logic                  rvalid0;
   logic                  rvalid1;
   logic [DATA_WIDTH-1:0] rdata0;
   logic [DATA_WIDTH-1:0] rdata1;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] mem_out;

   // Arbiter side.
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_addr, mem_data
   );

   // Requesters plus memory side.
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port memory: alternating ownership on contention,
// bounded bursts, registered grants and per-requester read-valid tracking.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic [3:0] cnt_q, cnt_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       rvalid0_q, rvalid0_d;
   logic       rvalid1_q, rvalid1_d;

   logic       acc0;
   logic       acc1;
   logic [3:0] cnt_inc;

   assign acc0    = (state_q == OWN0) && bus.req0;
   assign acc1    = (state_q == OWN1) && bus.req1;
   assign cnt_inc = cnt_q + 4'd1;

   assign bus.mem_we   = acc0 ? bus.we0    : (acc1 ? bus.we1    : 1'b0);
   assign bus.mem_addr = acc0 ? bus.addr0  : (acc1 ? bus.addr1  : '0);
   assign bus.mem_data = acc0 ? bus.wdata0 : (acc1 ? bus.wdata1 : '0);

   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;
   assign bus.rdata0  = bus.mem_out;
   assign bus.rdata1  = bus.mem_out;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            // On contention the requester that did not own last wins.
            if (bus.req0 && (!bus.req1 || last_q)) begin
               state_d = OWN0;
            end else if (bus.req1) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (!bus.req0) begin
               state_d = bus.req1 ? OWN1 : IDLE;
            end else if (cnt_inc == BURST_LIMIT) begin
               if (bus.req1) begin
                  state_d = OWN1;
               end else begin
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         OWN1: begin
            if (!bus.req1) begin
               state_d = bus.req0 ? OWN0 : IDLE;
            end else if (cnt_inc == BURST_LIMIT) begin
               if (bus.req0) begin
                  state_d = OWN0;
               end else begin
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase

      // Entry into an owner state: record the owner and restart the burst count.
      if ((state_d != state_q) && (state_d != IDLE)) begin
         last_d = (state_d == OWN1);
         cnt_d  = '0;
      end

      gnt0_d    = (state_d == OWN0);
      gnt1_d    = (state_d == OWN1);
      rvalid0_d = acc0 && !bus.we0;
      rvalid1_d = acc1 && !bus.we1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a reference model predicts each cycle's
// grants, memory port and read returns; a negedge monitor compares against the DUT.
module tb_mem_arbiter;
   localparam int AW = 6;
   localparam int DW = 16;
   localparam int MB = 4;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_BURST (MB)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Synchronous memory: data for an address appears on mem_out one cycle later.
   logic [DW-1:0] env_mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_data;
      bus.mem_out <= env_mem[bus.mem_addr];
   end

   typedef struct {
      logic          g0, g1, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          rv0, rv1;
   } exp_t;

   typedef struct {
      logic          known;
      logic [DW-1:0] d;
   } rd_t;

   exp_t exp_q[$];
   rd_t  rd_q0[$];
   rd_t  rd_q1[$];

   int checks = 0;
   int failures = 0;

   // Reference model state: owner -1 means nobody owns the port.
   int            owner = -1;
   int            last  = 1;
   int            run   = 0;
   bit            pend[2];
   logic [DW-1:0] mdl_mem  [0:DEPTH-1];
   bit            mdl_known[0:DEPTH-1];

   bit            c_req[2];
   bit            c_we[2];
   logic [AW-1:0] c_addr[2];
   logic [DW-1:0] c_data[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void grant(input int x);
      owner = x;
      last  = x;
      run   = 0;
   endfunction

   // Advance the model across one rising edge using the inputs held during the past cycle.
   function automatic void model_edge();
      bit   nxt[2];
      int   o;
      rd_t  r;
      nxt[0] = 1'b0;
      nxt[1] = 1'b0;
      o = owner;
      if (o >= 0 && c_req[o]) begin
         if (c_we[o]) begin
            mdl_mem[c_addr[o]]   = c_data[o];
            mdl_known[c_addr[o]] = 1'b1;
         end else begin
            nxt[o]  = 1'b1;
            r.known = mdl_known[c_addr[o]];
            r.d     = mdl_mem[c_addr[o]];
            if (o == 0) rd_q0.push_back(r);
            else        rd_q1.push_back(r);
         end
         run++;
         if (run == MB) begin
            run = 0;
            if (c_req[1-o]) grant(1 - o);
         end
      end else if (o >= 0) begin
         if (c_req[1-o]) grant(1 - o);
         else            owner = -1;
      end else begin
         if (c_req[0] && c_req[1]) grant(1 - last);
         else if (c_req[0])        grant(0);
         else if (c_req[1])        grant(1);
      end
      pend[0] = nxt[0];
      pend[1] = nxt[1];
   endfunction

   function automatic void push_exp();
      exp_t e;
      bit   acc;
      acc    = (owner >= 0) ? c_req[owner] : 1'b0;
      e.g0   = (owner == 0);
      e.g1   = (owner == 1);
      e.we   = acc ? c_we[owner]   : 1'b0;
      e.addr = acc ? c_addr[owner] : '0;
      e.data = acc ? c_data[owner] : '0;
      e.rv0  = pend[0];
      e.rv1  = pend[1];
      exp_q.push_back(e);
   endfunction

   task automatic drive_inputs();
      bus.req0   = c_req[0];
      bus.we0    = c_we[0];
      bus.addr0  = c_addr[0];
      bus.wdata0 = c_data[0];
      bus.req1   = c_req[1];
      bus.we1    = c_we[1];
      bus.addr1  = c_addr[1];
      bus.wdata1 = c_data[1];
   endtask

   task automatic step(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      @(posedge clk);
      #1;
      model_edge();
      c_req[0] = r0; c_we[0] = w0; c_addr[0] = a0; c_data[0] = d0;
      c_req[1] = r1; c_we[1] = w1; c_addr[1] = a1; c_data[1] = d1;
      drive_inputs();
      push_exp();
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", {62'd0, bus.gnt1, bus.gnt0}, 64'd0);
      chk("rst_mem_port", {41'd0, bus.mem_we, bus.mem_addr, bus.mem_data}, 64'd0);
      chk("rst_rvalid", {62'd0, bus.rvalid1, bus.rvalid0}, 64'd0);
      for (int k = 0; k < 2; k++) begin
         c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_data[k] = '0;
         pend[k]  = 1'b0;
      end
      drive_inputs();
      exp_q.delete();
      rd_q0.delete();
      rd_q1.delete();
      owner = -1;
      last  = 1;
      run   = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   exp_t mon_e;
   rd_t  mon_r;
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("gnt", {62'd0, bus.gnt1, bus.gnt0}, {62'd0, mon_e.g1, mon_e.g0});
            chk("mem_port", {41'd0, bus.mem_we, bus.mem_addr, bus.mem_data},
                {41'd0, mon_e.we, mon_e.addr, mon_e.data});
            chk("rvalid", {62'd0, bus.rvalid1, bus.rvalid0}, {62'd0, mon_e.rv1, mon_e.rv0});
         end
         if (bus.rvalid0) begin
            if (rd_q0.size() == 0) begin
               checks++; failures++;
               $display("FAIL rdata0_unexpected: got rvalid0=1 expected no pending read (t=%0t)", $time);
            end else begin
               mon_r = rd_q0.pop_front();
               if (mon_r.known) chk("rdata0", {48'd0, bus.rdata0}, {48'd0, mon_r.d});
            end
         end
         if (bus.rvalid1) begin
            if (rd_q1.size() == 0) begin
               checks++; failures++;
               $display("FAIL rdata1_unexpected: got rvalid1=1 expected no pending read (t=%0t)", $time);
            end else begin
               mon_r = rd_q1.pop_front();
               if (mon_r.known) chk("rdata1", {48'd0, bus.rdata1}, {48'd0, mon_r.d});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit            r[2];
      bit            w0, w1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;

      for (int k = 0; k < DEPTH; k++) mdl_known[k] = 1'b0;
      #1;
      do_reset();

      // Write 0x1234 to address 5, read it back.
      step(1'b1, 1'b1, 6'd5, 16'h1234, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b1, 6'd5, 16'h1234, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, 6'd5, 16'h0000, 1'b0, 1'b0, '0, '0);
      idle_step();
      idle_step();

      // Simultaneous requests right after reset; requester 0 wins first.
      #2;
      do_reset();
      repeat (3) step(1'b1, 1'b1, 6'd9, 16'hA5A5, 1'b1, 1'b0, 6'd5, '0);
      repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd9, '0);
      idle_step();

      // Both held continuously: alternating bursts of MAX_BURST.
      for (int i = 0; i < 20; i++)
         step(1'b1, 1'b1, 6'(i), 16'(i * 3), 1'b1, 1'b0, 6'(i), '0);
      idle_step();
      idle_step();

      // Only requester 1 for a long run: no gap at counter wrap.
      for (int i = 0; i < 12; i++)
         step(1'b0, 1'b0, '0, '0, 1'b1, 1'(i % 2), 6'(i + 20), 16'(i + 100));
      idle_step();

      // Reset during OWN1 while a read return is in flight.
      repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd9, '0);
      #2;
      do_reset();
      step(1'b1, 1'b0, 6'd9, '0, 1'b1, 1'b0, 6'd5, '0);
      step(1'b1, 1'b0, 6'd9, '0, 1'b1, 1'b0, 6'd5, '0);
      idle_step();
      idle_step();

      // Randomised traffic with occasional mid-run resets.
      r[0] = 1'b0;
      r[1] = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         for (int k = 0; k < 2; k++)
            if ($urandom_range(0, 3) == 0) r[k] = ~r[k];
         w0 = 1'($urandom_range(0, 1));
         w1 = 1'($urandom_range(0, 1));
         a0 = AW'($urandom_range(0, 15));
         a1 = AW'($urandom_range(0, 15));
         d0 = DW'($urandom);
         d1 = DW'($urandom);
         step(r[0], w0, a0, d0, r[1], w1, a1, d1);
         if ($urandom_range(0, 299) == 0) begin
            #2;
            do_reset();
            r[0] = 1'b0;
            r[1] = 1'b0;
         end
      end

      repeat (3) idle_step();
      @(negedge clk);
      #1;
      chk("rd0_drained", 64'(rd_q0.size()), 64'd0);
      chk("rd1_drained", 64'(rd_q1.size()), 64'd0);
      chk("exp_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
